// File: rtl/uart_tx_scheduler.sv
// Round-robin arbitration of two byte requesters into a shared FIFO feeding one UART sender.
// Optional WAIT_BUSY timeout with sticky error flag: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int DEPTH        = 4,
  parameter int PULSE_CYCLES = 325
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [7:0]               req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [7:0]               req1_data,
  output logic                     req1_ready,
  input  logic                     tx_status,
  output logic [7:0]               tx_data,
  output logic                     tx_en,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [15:0]   PULSE_LAST = 16'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_PULSE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_IDLE = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_last;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [7:0]      r_mem [DEPTH];
  logic [15:0]     r_cnt;
  logic [7:0]      r_tx_data;
  logic            r_tx_en;

  logic w_full, w_grant0, w_grant1, w_push0, w_push1, w_push;
  logic [7:0] w_push_data;
  logic w_pop, w_cnt_inc, w_pulse_done, w_timeout;

  // Requester 0 wins ties when requester 1 was last served, and vice versa.
  assign w_full      = (r_count == FULL_CNT);
  assign w_grant0    = req0_valid & (~req1_valid | r_last);
  assign w_grant1    = req1_valid & (~req0_valid | ~r_last);
  assign req0_ready  = w_grant0 & ~w_full;
  assign req1_ready  = w_grant1 & ~w_full;
  assign w_push0     = req0_valid & req0_ready;
  assign w_push1     = req1_valid & req1_ready;
  assign w_push      = w_push0 | w_push1;
  assign w_push_data = w_push0 ? req0_data : req1_data;

  assign tx_data    = r_tx_data;
  assign tx_en      = r_tx_en;
  assign fifo_count = r_count;
  assign busy       = (r_count != CW'(0)) | (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_pop)        w_state_next = S_PULSE;
      S_PULSE:     if (w_pulse_done) w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!tx_status)     w_state_next = S_WAIT_IDLE;
        else if (w_timeout) w_state_next = S_IDLE;
        else                w_state_next = S_WAIT_BUSY;
      end
      S_WAIT_IDLE: if (tx_status)    w_state_next = S_IDLE;
      default:                       w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop        = (r_state == S_IDLE) & (r_count != CW'(0)) & tx_status;
    w_pulse_done = (r_state == S_PULSE) & (r_cnt == PULSE_LAST);
`ifdef UART_TX_SCHED_TIMEOUT_EN
    w_timeout    = (r_state == S_WAIT_BUSY) & tx_status & (r_cnt == PULSE_LAST);
    w_cnt_inc    = (r_state == S_PULSE) | (r_state == S_WAIT_BUSY);
`else
    w_timeout    = 1'b0;
    w_cnt_inc    = (r_state == S_PULSE);
`endif
  end

  // Counter restarts on every state change so PULSE and WAIT_BUSY each start from zero.
  always_ff @(posedge clk) begin
    if (reset)                         r_cnt <= 16'd0;
    else if (w_state_next != r_state)  r_cnt <= 16'd0;
    else if (w_cnt_inc)                r_cnt <= r_cnt + 16'd1;
    else                               r_cnt <= r_cnt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_en   <= 1'b0;
      r_tx_data <= 8'd0;
    end else if (w_pop) begin
      r_tx_en   <= 1'b1;
      r_tx_data <= r_mem[r_rd_ptr];
    end else if (w_pulse_done) begin
      r_tx_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_last   <= w_push1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef UART_TX_SCHED_TIMEOUT_EN
  logic r_timeout_err;

  always_ff @(posedge clk) begin
    if (reset)          r_timeout_err <= 1'b0;
    else if (w_timeout) r_timeout_err <= 1'b1;
  end

  assign timeout_err = r_timeout_err;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: arbitration order, FIFO full/drain, pulse length,
// push/pop overlap, reset mid-pulse and the WAIT_BUSY timeout (both macro settings).
module tb_uart_tx_scheduler;

  localparam int PULSE = 325;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       tx_status;
  logic [7:0] tx_data;
  logic       tx_en, busy, timeout_err;
  logic [2:0] fifo_count;

  int n_assert = 0;
  int n_fail   = 0;

  uart_tx_scheduler #(.DEPTH(4), .PULSE_CYCLES(PULSE)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx_status(tx_status), .tx_data(tx_data), .tx_en(tx_en), .busy(busy),
    .fifo_count(fifo_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int i;
    i = 0;
    while (tx_en !== 1'b1 && i < 1000) begin
      tick();
      i++;
    end
    chk({tag, "_en_seen"}, 32'(tx_en), 32'd1);
  endtask

  // Sender goes busy, stays busy past the pulse, then returns idle.
  task automatic finish_byte();
    tx_status = 1'b0;
    repeat (PULSE + 5) tick();
    tx_status = 1'b1;
    tick();
  endtask

  task automatic serve(input logic [7:0] exp, input string tag);
    wait_en(tag);
    chk(tag, 32'(tx_data), 32'(exp));
    finish_byte();
  endtask

  initial begin
    bit [5:0] exp_r0;
    bit [5:0] exp_r1;
    int rises;
    logic prev_en;

    reset = 1'b1; tx_status = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
    tick(); tick();
    chk("rst_tx_en",   32'(tx_en),       32'd0);
    chk("rst_tx_data", 32'(tx_data),     32'd0);
    chk("rst_count",   32'(fifo_count),  32'd0);
    chk("rst_busy",    32'(busy),        32'd0);
    chk("rst_tmo",     32'(timeout_err), 32'd0);
    reset = 1'b0;

    // first contest goes to requester 0
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    chk("arb_first_r0", 32'(req0_ready), 32'd1);
    chk("arb_first_r1", 32'(req1_ready), 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;

    // basic send
    tick();
    req0_valid = 1'b1; req0_data = 8'h41;
    tick();
    req0_valid = 1'b0;
    chk("basic_count1", 32'(fifo_count), 32'd1);
    chk("basic_en_lo",  32'(tx_en),      32'd0);
    tick();
    chk("basic_en_hi",  32'(tx_en),      32'd1);
    chk("basic_data",   32'(tx_data),    32'h41);
    chk("basic_count0", 32'(fifo_count), 32'd0);
    chk("basic_busy",   32'(busy),       32'd1);
    repeat (PULSE - 1) tick();
    chk("basic_en_last", 32'(tx_en), 32'd1);
    tick();
    chk("basic_en_fall", 32'(tx_en), 32'd0);
    tx_status = 1'b0;
    repeat (100) tick();
    chk("basic_busy_mid", 32'(busy), 32'd1);
    tx_status = 1'b1;
    tick();
    chk("basic_busy_end", 32'(busy), 32'd0);

    // contention: accept order A0, B0, A0, B0, then full
    do_reset();
    tx_status = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hA0;
    req1_valid = 1'b1; req1_data = 8'hB0;
    exp_r0 = 6'b000101;
    exp_r1 = 6'b001010;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("cont_r0_%0d", i), 32'(req0_ready), 32'(exp_r0[i]));
      chk($sformatf("cont_r1_%0d", i), 32'(req1_ready), 32'(exp_r1[i]));
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("cont_count", 32'(fifo_count), 32'd4);
    tx_status = 1'b1;
    serve(8'hA0, "cont_tx0");
    serve(8'hB0, "cont_tx1");
    serve(8'hA0, "cont_tx2");
    serve(8'hB0, "cont_tx3");

    // full FIFO: 5 pushes, 4 accepted, drain in order
    do_reset();
    tx_status = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req0_data = 8'(i + 1);
      #1;
      chk($sformatf("full_ready_%0d", i), 32'(req0_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_ready_held", 32'(req0_ready), 32'd0);
    req0_valid = 1'b0;
    tx_status = 1'b1;
    for (int i = 0; i < 4; i++) serve(8'(i + 1), $sformatf("full_drain_%0d", i));
    chk("full_empty", 32'(fifo_count), 32'd0);
    chk("full_idle",  32'(busy),       32'd0);

    // simultaneous push and pop from count=1
    do_reset();
    tx_status = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h11;
    tick();
    req0_valid = 1'b0;
    tx_status = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h22;
    tick();
    req1_valid = 1'b0;
    chk("pp_count", 32'(fifo_count), 32'd1);
    chk("pp_en",    32'(tx_en),      32'd1);
    chk("pp_data",  32'(tx_data),    32'h11);
    finish_byte();
    serve(8'h22, "pp_second");

    // reset mid-pulse with three bytes queued
    do_reset();
    tx_status = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'hC1; tick();
    req0_data = 8'hC2; tick();
    req0_data = 8'hC3; tick();
    req0_data = 8'hC4; tick();
    req0_valid = 1'b0;
    chk("rm_count3", 32'(fifo_count), 32'd3);
    chk("rm_data",   32'(tx_data),    32'hC1);
    repeat (96) tick();
    chk("rm_en_pre", 32'(tx_en), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rm_en",    32'(tx_en),      32'd0);
    chk("rm_count", 32'(fifo_count), 32'd0);
    chk("rm_busy",  32'(busy),       32'd0);
    rises = 0;
    prev_en = tx_en;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (tx_en === 1'b1 && prev_en !== 1'b1) rises++;
      prev_en = tx_en;
    end
    chk("rm_no_rise", 32'(rises), 32'd0);

    // sender never goes busy
    do_reset();
    tx_status = 1'b1;
    req0_valid = 1'b1;
    req0_data = 8'h5A; tick();
    req0_data = 8'h6B; tick();
    req0_valid = 1'b0;
    chk("tmo_first", 32'(tx_data), 32'h5A);
    repeat (649) tick();
    chk("tmo_flag_pre", 32'(timeout_err), 32'd0);
    tick();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    chk("tmo_flag",   32'(timeout_err), 32'd1);
    chk("tmo_en_lo",  32'(tx_en),       32'd0);
    tick();
    chk("tmo_next_en",   32'(tx_en),      32'd1);
    chk("tmo_next_data", 32'(tx_data),    32'h6B);
    chk("tmo_count",     32'(fifo_count), 32'd0);
    chk("tmo_sticky",    32'(timeout_err), 32'd1);
`else
    chk("tmo_flag",   32'(timeout_err), 32'd0);
    tick();
    chk("tmo_stuck_en",    32'(tx_en),      32'd0);
    chk("tmo_stuck_count", 32'(fifo_count), 32'd1);
    chk("tmo_stuck_busy",  32'(busy),       32'd1);
    repeat (500) tick();
    chk("tmo_still_en",  32'(tx_en),       32'd0);
    chk("tmo_still_flag", 32'(timeout_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
